board_judge: RTL and testbench

Board store and win/tie detector that sits directly downstream of the game controller FSM. Each cycle it samples the controller's cell address and cell-state request and commits legal moves into a 9-cell board register. After every committed move it scans the eight winning lines and raises the `gameIsDone` flag that the controller consumes. It also exposes the packed board for the display path.

---
 rtl/tictactoe_pkg.sv | 37 +++
 rtl/board_judge_if.sv | 25 ++
 rtl/line_check.sv | 15 +
 rtl/board_judge.sv | 161 ++++++++++++++++
 tb/tb_board_judge.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// Shared game types: cell/winner/judge-state encodings and the winning-line table.
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    WRITE_X = 2'b10,
    WRITE_O = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    NO_WIN      = 2'b00,
    TIE         = 2'b01,
    PLAYER2_WIN = 2'b10,
    PLAYER1_WIN = 2'b11
  } winnerType;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } judgeStateType;

  localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/board_judge_if.sv
// Controller <-> judge bundle: move request in, board and result flags out.
interface board_judge_if;
  import tictactoe_pkg::*;

  logic [3:0]             addr;
  logic [1:0]             cellState;
  logic [2*NUM_CELLS-1:0] cells;
  logic                   writeAccepted;
  logic                   writeRejected;
  logic                   scanBusy;
  logic                   gameIsDone;
  logic [1:0]             winner;
  logic [2:0]             winLine;

  modport master (
    output addr, cellState,
    input  cells, writeAccepted, writeRejected, scanBusy, gameIsDone, winner, winLine
  );

  modport slave (
    input  addr, cellState,
    output cells, writeAccepted, writeRejected, scanBusy, gameIsDone, winner, winLine
  );

endinterface

// File: rtl/line_check.sv
// Combinational test of one three-cell line: win when all equal and non-empty.
module line_check
  import tictactoe_pkg::*;
(
  input  cellStateType a_i,
  input  cellStateType b_i,
  input  cellStateType c_i,
  output logic         win_o,
  output cellStateType owner_o
);

  assign win_o   = (a_i != EMPTY) && (a_i == b_i) && (b_i == c_i);
  assign owner_o = win_o ? a_i : EMPTY;

endmodule

// File: rtl/board_judge.sv
// Board register plus win/tie scanner. Default scans one line per cycle;
// defining BOARD_JUDGE_PARALLEL_EN checks all eight lines in a single cycle.
module board_judge
  import tictactoe_pkg::*;
(
  input  logic          ph1,
  input  logic          reset,
  board_judge_if.slave  bus
);

  logic [NUM_CELLS-1:0][1:0] cells_d, cells_q;
  judgeStateType             state_d, state_q;
  logic                      accepted_d, accepted_q;
  logic                      rejected_d, rejected_q;
  logic                      done_d, done_q;
  winnerType                 winner_d, winner_q;
  logic [2:0]                win_line_d, win_line_q;

  logic                      addr_ok;
  logic [3:0]                addr_idx;
  logic                      accept;
  logic                      board_full;
  logic                      scan_win;
  logic                      scan_last;
  cellStateType              scan_owner;
  logic [2:0]                scan_line;

  always_comb begin
    addr_ok  = (bus.addr <= 4'd8);
    addr_idx = addr_ok ? bus.addr : 4'd0;
    accept   = addr_ok && (state_q == IDLE) && (cells_q[addr_idx] == EMPTY)
               && (bus.cellState != EMPTY);
    board_full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cells_q[i] == EMPTY) board_full = 1'b0;
    end
  end

`ifdef BOARD_JUDGE_PARALLEL_EN
  logic [NUM_LINES-1:0] line_win;
  cellStateType         line_owner [NUM_LINES];

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    line_check u_line_check (
      .a_i     (cellStateType'(cells_q[LINE_TABLE[g][0]])),
      .b_i     (cellStateType'(cells_q[LINE_TABLE[g][1]])),
      .c_i     (cellStateType'(cells_q[LINE_TABLE[g][2]])),
      .win_o   (line_win[g]),
      .owner_o (line_owner[g])
    );
  end

  // Descending walk so the lowest-indexed winning line is the one reported.
  always_comb begin
    scan_win   = 1'b0;
    scan_owner = EMPTY;
    scan_line  = 3'd0;
    scan_last  = 1'b1;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (line_win[i]) begin
        scan_win   = 1'b1;
        scan_owner = line_owner[i];
        scan_line  = 3'(i);
      end
    end
  end
`else
  logic [2:0] line_idx_d, line_idx_q;

  line_check u_line_check (
    .a_i     (cellStateType'(cells_q[LINE_TABLE[line_idx_q][0]])),
    .b_i     (cellStateType'(cells_q[LINE_TABLE[line_idx_q][1]])),
    .c_i     (cellStateType'(cells_q[LINE_TABLE[line_idx_q][2]])),
    .win_o   (scan_win),
    .owner_o (scan_owner)
  );

  always_comb begin
    scan_line  = line_idx_q;
    scan_last  = (line_idx_q == 3'd7);
    line_idx_d = line_idx_q;
    if (accept)                line_idx_d = 3'd0;
    else if (state_q == SCAN)  line_idx_d = line_idx_q + 3'd1;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) line_idx_q <= 3'd0;
    else       line_idx_q <= line_idx_d;
  end
`endif

  always_comb begin
    cells_d    = cells_q;
    state_d    = state_q;
    accepted_d = 1'b0;
    rejected_d = 1'b0;
    done_d     = done_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;

    if (addr_ok) begin
      if (accept) begin
        cells_d[addr_idx] = bus.cellState;
        accepted_d        = 1'b1;
      end else begin
        rejected_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: begin
        if (scan_win) begin
          winner_d   = winnerType'(scan_owner);
          win_line_d = scan_line;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (scan_last) begin
          if (board_full) begin
            winner_d = TIE;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      cells_q    <= '0;
      state_q    <= IDLE;
      accepted_q <= 1'b0;
      rejected_q <= 1'b0;
      done_q     <= 1'b0;
      winner_q   <= NO_WIN;
      win_line_q <= 3'd0;
    end else begin
      cells_q    <= cells_d;
      state_q    <= state_d;
      accepted_q <= accepted_d;
      rejected_q <= rejected_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
    end
  end

  assign bus.cells         = cells_q;
  assign bus.writeAccepted = accepted_q;
  assign bus.writeRejected = rejected_q;
  assign bus.scanBusy      = (state_q == SCAN);
  assign bus.gameIsDone    = done_q;
  assign bus.winner        = winner_q;
  assign bus.winLine       = win_line_q;

endmodule

// File: tb/tb_board_judge.sv
// Directed game scenarios followed by random play, checked every cycle against a board-level model.
module tb_board_judge;

  logic ph1 = 1'b0;
  logic reset;
  always #5 ph1 = ~ph1;

  board_judge_if bus ();

  board_judge dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int LT [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic [1:0] mb [9];
  int         m_left;
  bit         m_done;
  logic [1:0] m_win;
  logic [2:0] m_line;
  logic       m_acc, m_rej;
  logic [1:0] p_win;
  logic [2:0] p_line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] packed_board();
    logic [17:0] pb;
    for (int i = 0; i < 9; i++) pb[2*i +: 2] = mb[i];
    return pb;
  endfunction

  task automatic check_all();
    chk("cells", 32'(bus.cells), 32'(packed_board()));
    chk("writeAccepted", 32'(bus.writeAccepted), 32'(m_acc));
    chk("writeRejected", 32'(bus.writeRejected), 32'(m_rej));
    chk("scanBusy", 32'(bus.scanBusy), 32'(m_left > 0));
    chk("gameIsDone", 32'(bus.gameIsDone), 32'(m_done));
    chk("winner", 32'(bus.winner), 32'(m_win));
    if (m_win[1]) chk("winLine", 32'(bus.winLine), 32'(m_line));
  endtask

  // Decide the outcome of the board as it stands and how long the judge takes to report it.
  task automatic evaluate();
    int k = -1;
    bit full = 1'b1;
    for (int l = 7; l >= 0; l--) begin
      if (mb[LT[l][0]] != 2'b00 && mb[LT[l][0]] == mb[LT[l][1]] && mb[LT[l][1]] == mb[LT[l][2]])
        k = l;
    end
    for (int i = 0; i < 9; i++) if (mb[i] == 2'b00) full = 1'b0;
    if (k >= 0) begin
      p_win  = mb[LT[k][0]];
      p_line = 3'(k);
    end else begin
      p_win  = full ? 2'b01 : 2'b00;
      p_line = 3'd0;
    end
`ifdef BOARD_JUDGE_PARALLEL_EN
    m_left = 1;
`else
    m_left = (k >= 0) ? k + 1 : 8;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mb[i] = 2'b00;
    m_left = 0; m_done = 1'b0; m_win = 2'b00; m_line = 3'd0;
    m_acc = 1'b0; m_rej = 1'b0;
  endtask

  // Called 1ns after a rising edge: reset must take effect without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("reset_winLine", 32'(bus.winLine), 32'd0);
    reset = 1'b0;
  endtask

  task automatic tick(input logic [3:0] a, input logic [1:0] v);
    bit idle_before;
    idle_before   = (m_left == 0) && !m_done;
    bus.addr      = a;
    bus.cellState = v;
    @(posedge ph1);
    #1;
    m_acc = 1'b0;
    m_rej = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_win != 2'b00) begin
        m_done = 1'b1;
        m_win  = p_win;
        if (p_win != 2'b01) m_line = p_line;
      end
    end
    if (a <= 4'd8) begin
      if (idle_before && mb[a] == 2'b00 && v != 2'b00) begin
        m_acc = 1'b1;
        mb[a] = v;
        evaluate();
      end else begin
        m_rej = 1'b1;
      end
    end
    bus.addr      = 4'hF;
    bus.cellState = 2'b00;
    check_all();
  endtask

  task automatic wait_idle();
    while (m_left > 0) tick(4'hF, 2'b00);
  endtask

  initial begin
    logic [3:0] ra;
    logic [1:0] rv;
    int         r;

    reset         = 1'b1;
    bus.addr      = 4'hF;
    bus.cellState = 2'b00;
    model_clear();
    @(posedge ph1);
    #1;
    do_reset();

    // Single O in the centre: no result, back to idle.
    tick(4'd4, 2'b11);
    chk("t1_accept", 32'(bus.writeAccepted), 32'd1);
    chk("t1_cell4", 32'(bus.cells[9:8]), 32'd3);
    chk("t1_busy", 32'(bus.scanBusy), 32'd1);
    wait_idle();
    chk("t1_idle", 32'(bus.scanBusy), 32'd0);
    chk("t1_nowin", 32'(bus.winner), 32'd0);

    tick(4'd4, 2'b10);
    chk("rej_occupied", 32'(bus.writeRejected), 32'd1);
    tick(4'd0, 2'b00);
    chk("rej_empty_state", 32'(bus.writeRejected), 32'd1);
    tick(4'd0, 2'b11);
    tick(4'd1, 2'b10);
    chk("rej_during_scan", 32'(bus.writeRejected), 32'd1);
    chk("rej_scan_cell1", 32'(bus.cells[3:2]), 32'd0);
    wait_idle();
    tick(4'hF, 2'b11);
    chk("addr15_no_acc", 32'(bus.writeAccepted), 32'd0);
    chk("addr15_no_rej", 32'(bus.writeRejected), 32'd0);

    // O takes the top row.
    do_reset();
    tick(4'd0, 2'b11); wait_idle();
    tick(4'd1, 2'b11); wait_idle();
    tick(4'd2, 2'b11);
    tick(4'hF, 2'b00);
    chk("row0_done", 32'(bus.gameIsDone), 32'd1);
    chk("row0_winner", 32'(bus.winner), 32'd3);
    chk("row0_line", 32'(bus.winLine), 32'd0);
    tick(4'd5, 2'b10);
    chk("rej_in_done", 32'(bus.writeRejected), 32'd1);

    // X takes the anti-diagonal.
    do_reset();
    tick(4'd2, 2'b10); wait_idle();
    tick(4'd4, 2'b10); wait_idle();
    tick(4'd6, 2'b10); wait_idle();
    chk("diag_done", 32'(bus.gameIsDone), 32'd1);
    chk("diag_winner", 32'(bus.winner), 32'd2);
    chk("diag_line", 32'(bus.winLine), 32'd7);

    // Full board with no line.
    do_reset();
    tick(4'd0, 2'b11); wait_idle();
    tick(4'd1, 2'b10); wait_idle();
    tick(4'd2, 2'b11); wait_idle();
    tick(4'd4, 2'b10); wait_idle();
    tick(4'd3, 2'b11); wait_idle();
    tick(4'd5, 2'b10); wait_idle();
    tick(4'd7, 2'b11); wait_idle();
    tick(4'd6, 2'b10); wait_idle();
    tick(4'd8, 2'b11); wait_idle();
    chk("tie_winner", 32'(bus.winner), 32'd1);
    chk("tie_done", 32'(bus.gameIsDone), 32'd1);

    // Reset three cycles into a scan, then play on normally.
    do_reset();
    tick(4'd4, 2'b11);
    tick(4'hF, 2'b00);
    tick(4'hF, 2'b00);
    tick(4'hF, 2'b00);
    do_reset();
    chk("abort_busy", 32'(bus.scanBusy), 32'd0);
    chk("abort_cells", 32'(bus.cells), 32'd0);
    tick(4'd4, 2'b11);
    chk("after_abort_accept", 32'(bus.writeAccepted), 32'd1);
    wait_idle();

    // Random play.
    for (int i = 0; i < 1500; i++) begin
      if (m_done && $urandom_range(0, 5) == 0) begin
        do_reset();
      end else if (m_left > 0 && $urandom_range(0, 40) == 0) begin
        do_reset();
      end else begin
        ra = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        r  = $urandom_range(0, 9);
        rv = (r == 0) ? 2'b00 : ((r % 2 == 1) ? 2'b10 : 2'b11);
        tick(ra, rv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
